// File: rtl/if_id_fifo.sv
// IF/ID decoupling FIFO with predecode branch prediction for conditional branches and JAL.
// Optional macro IF_ID_BHT_EN replaces static backward-taken with a 2-bit saturating BHT.
module if_id_fifo #(
  parameter int ADDR_W    = 32,
  parameter int INST_W    = 32,
  parameter int DEPTH     = 4,
  parameter int BHT_IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              pred_flag,
  output logic [ADDR_W-1:0] pred_tar_addr,
  input  logic              stall_id,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_pred_taken,
  output logic [ADDR_W-1:0] id_pred_target,
  input  logic              ex_br_valid,
  input  logic [ADDR_W-1:0] ex_br_pc,
  input  logic              ex_br_taken
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       OP_JAL    = 7'b1101111;

  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
  logic [INST_W-1:0] inst_mem_r  [DEPTH];
  logic              taken_mem_r [DEPTH];
  logic [ADDR_W-1:0] tar_mem_r   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic              full_s;
  logic              empty_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              br_taken_s;
  logic signed [31:0] b_imm_s;
  logic signed [31:0] j_imm_s;
  logic              pred_flag_s;
  logic [ADDR_W-1:0] pred_tar_s;

  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  // Held low during reset so nothing is accepted or predicted.
  assign accept_s = !rst && !full_s;
  assign if_ready = accept_s;
  assign push_s   = if_valid && accept_s && !flush;
  assign pop_s    = !empty_s && !stall_id && !flush;

  assign b_imm_s = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign j_imm_s = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

`ifdef IF_ID_BHT_EN
  logic [1:0]           bht_r [2**BHT_IDX_W];
  logic [BHT_IDX_W-1:0] rd_idx_s;
  logic [BHT_IDX_W-1:0] up_idx_s;
  logic                 unused_ex_s;

  assign rd_idx_s    = if_pc[BHT_IDX_W+1:2];
  assign up_idx_s    = ex_br_pc[BHT_IDX_W+1:2];
  // Reads see the registered counter, i.e. the pre-update value on a same-index collision.
  assign br_taken_s  = bht_r[rd_idx_s][1];
  assign unused_ex_s = ^{ex_br_pc[ADDR_W-1:BHT_IDX_W+2], ex_br_pc[1:0]};

  // Saturating counter training from resolved branches; flush leaves history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (ex_br_valid) begin
      if (ex_br_taken && (bht_r[up_idx_s] != 2'b11)) begin
        bht_r[up_idx_s] <= bht_r[up_idx_s] + 2'b01;
      end else if (!ex_br_taken && (bht_r[up_idx_s] != 2'b00)) begin
        bht_r[up_idx_s] <= bht_r[up_idx_s] - 2'b01;
      end
    end
  end
`else
  logic unused_ex_s;

  assign br_taken_s  = if_inst[31];
  assign unused_ex_s = ^{ex_br_valid, ex_br_pc, ex_br_taken};
`endif

  // Predecode of the incoming fetch word into a redirect request.
  always_comb begin
    pred_flag_s = 1'b0;
    pred_tar_s  = {ADDR_W{1'b0}};
    if (if_valid && accept_s) begin
      case (if_inst[6:0])
        OP_BRANCH: begin
          if (br_taken_s) begin
            pred_flag_s = 1'b1;
            pred_tar_s  = if_pc + ADDR_W'(b_imm_s);
          end else begin
            pred_flag_s = 1'b0;
          end
        end
        OP_JAL: begin
          pred_flag_s = 1'b1;
          pred_tar_s  = if_pc + ADDR_W'(j_imm_s);
        end
        default: begin
          pred_flag_s = 1'b0;
        end
      endcase
    end else begin
      pred_flag_s = 1'b0;
    end
  end

  assign pred_flag     = pred_flag_s;
  assign pred_tar_addr = pred_tar_s;

  // Pointer and occupancy tracking; flush outranks push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage; stale contents are masked by the empty check on read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= if_pc;
      inst_mem_r[wr_ptr_r]  <= if_inst;
      taken_mem_r[wr_ptr_r] <= pred_flag_s;
      tar_mem_r[wr_ptr_r]   <= pred_tar_s;
    end
  end

  // Head entry presentation; an empty FIFO shows an all-zero bubble.
  always_comb begin
    id_valid       = 1'b0;
    id_pc          = {ADDR_W{1'b0}};
    id_inst        = {INST_W{1'b0}};
    id_pred_taken  = 1'b0;
    id_pred_target = {ADDR_W{1'b0}};
    if (!empty_s) begin
      id_valid       = 1'b1;
      id_pc          = pc_mem_r[rd_ptr_r];
      id_inst        = inst_mem_r[rd_ptr_r];
      id_pred_taken  = taken_mem_r[rd_ptr_r];
      id_pred_target = tar_mem_r[rd_ptr_r];
    end else begin
      id_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed self-checking bench for if_id_fifo; covers static prediction or,
// when IF_ID_BHT_EN is defined, the BHT training sequence.
module tb_if_id_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        pred_flag;
  logic [31:0] pred_tar_addr;
  logic        stall_id;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        ex_br_valid;
  logic [31:0] ex_br_pc;
  logic        ex_br_taken;

  int n_checks = 0;
  int n_errors = 0;

  if_id_fifo #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .BHT_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .pred_flag(pred_flag), .pred_tar_addr(pred_tar_addr),
    .stall_id(stall_id), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic probe(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_id = 1'b0;
    ex_br_valid = 1'b0; ex_br_pc = 32'h0; ex_br_taken = 1'b0;
    if_valid = 1'b1; if_pc = 32'h0; if_inst = 32'h0800006F;
    #1;
    check_eq("rst_if_ready", 64'(if_ready), 64'h0);
    check_eq("rst_pred_flag", 64'(pred_flag), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    if_valid = 1'b0;
    #1;
    check_eq("reset_id_valid", 64'(id_valid), 64'h0);
    check_eq("reset_id_pc", 64'(id_pc), 64'h0);
    check_eq("reset_id_inst", 64'(id_inst), 64'h0);
    check_eq("reset_id_pred_taken", 64'(id_pred_taken), 64'h0);
    check_eq("reset_id_pred_target", 64'(id_pred_target), 64'h0);
    check_eq("reset_if_ready", 64'(if_ready), 64'h1);

    // Fill under stall, then drain in order.
    stall_id = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'(i * 4), 32'h00100013 + 32'(i));
    check_eq("fill_if_ready", 64'(if_ready), 64'h0);
    check_eq("fill_id_valid", 64'(id_valid), 64'h1);
    check_eq("fill_id_pc", 64'(id_pc), 64'h0);
    stall_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_id_pc", 64'(id_pc), 64'(i * 4));
      check_eq("drain_id_inst", 64'(id_inst), 64'(32'h00100013 + 32'(i)));
      tick();
    end
    check_eq("drained_id_valid", 64'(id_valid), 64'h0);
    check_eq("drained_id_inst", 64'(id_inst), 64'h0);
    check_eq("drained_if_ready", 64'(if_ready), 64'h1);

    // Full FIFO: a same-cycle pop does not free a slot for the fetch word.
    stall_id = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h40 + 32'(i * 4), 32'h00000013);
    stall_id = 1'b0;
    probe(32'h200, 32'hFE000EE3);
    check_eq("full_pop_if_ready", 64'(if_ready), 64'h0);
    check_eq("full_pred_flag", 64'(pred_flag), 64'h0);
    tick();
    if_valid = 1'b0;
    check_eq("after_pop_if_ready", 64'(if_ready), 64'h1);
    for (int i = 1; i < 4; i++) begin
      check_eq("full_drain_pc", 64'(id_pc), 64'(32'h40 + 32'(i * 4)));
      tick();
    end
    check_eq("dropped_word_absent", 64'(id_valid), 64'h0);

    // Flush with 3 entries and a same-cycle fetch word.
    stall_id = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'h80 + 32'(i * 4), 32'h00000013);
    flush = 1'b1;
    if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h00000013;
    tick();
    flush = 1'b0; if_valid = 1'b0; stall_id = 1'b0;
    check_eq("flush_id_valid", 64'(id_valid), 64'h0);
    check_eq("flush_if_ready", 64'(if_ready), 64'h1);
    check_eq("flush_id_pc", 64'(id_pc), 64'h0);
    tick();
    check_eq("flush_word_absent", 64'(id_valid), 64'h0);

    // Single push: visible the cycle after the edge.
    push_word(32'h44, 32'h00500093);
    check_eq("latency_id_valid", 64'(id_valid), 64'h1);
    check_eq("latency_id_pc", 64'(id_pc), 64'h44);
    check_eq("latency_id_inst", 64'(id_inst), 64'h00500093);
    tick();
    check_eq("popped_id_valid", 64'(id_valid), 64'h0);

    // Predecode.
    probe(32'h100, 32'hFE000EE3);
`ifdef IF_ID_BHT_EN
    check_eq("beq_back_pred_bht_init", 64'(pred_flag), 64'h0);
`else
    check_eq("beq_back_pred", 64'(pred_flag), 64'h1);
    check_eq("beq_back_target", 64'(pred_tar_addr), 64'hFC);
`endif
    probe(32'h100, 32'h00000463);
    check_eq("beq_fwd_pred", 64'(pred_flag), 64'h0);
    probe(32'hFFFFFFF0, 32'h0800006F);
    check_eq("jal_wrap_pred", 64'(pred_flag), 64'h1);
    check_eq("jal_wrap_target", 64'(pred_tar_addr), 64'h70);
    probe(32'h100, 32'h80000067);
    check_eq("jalr_pred", 64'(pred_flag), 64'h0);
    if_valid = 1'b0; if_pc = 32'h100; if_inst = 32'hFE000EE3;
    #1;
    check_eq("idle_pred_flag", 64'(pred_flag), 64'h0);
    check_eq("idle_pred_target", 64'(pred_tar_addr), 64'h0);

    // Prediction travels with the stored entry.
    stall_id = 1'b1;
    push_word(32'h100, 32'hFE000EE3);
`ifdef IF_ID_BHT_EN
    check_eq("stored_pred_taken", 64'(id_pred_taken), 64'h0);
    check_eq("stored_pred_target", 64'(id_pred_target), 64'h0);
`else
    check_eq("stored_pred_taken", 64'(id_pred_taken), 64'h1);
    check_eq("stored_pred_target", 64'(id_pred_target), 64'hFC);
`endif
    stall_id = 1'b0;
    tick();

`ifdef IF_ID_BHT_EN
    // Train 01 -> 10 -> 11.
    ex_br_valid = 1'b1; ex_br_pc = 32'h100; ex_br_taken = 1'b1;
    tick();
    tick();
    ex_br_valid = 1'b0;
    probe(32'h100, 32'hFE000EE3);
    check_eq("bht_taken_pred", 64'(pred_flag), 64'h1);
    check_eq("bht_taken_target", 64'(pred_tar_addr), 64'hFC);
    if_valid = 1'b0;
    // 11 -> 10 -> 01 -> 00, then one more must hold at 00.
    ex_br_valid = 1'b1; ex_br_taken = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ex_br_valid = 1'b0;
    probe(32'h100, 32'hFE000EE3);
    check_eq("bht_nt_pred", 64'(pred_flag), 64'h0);
    if_valid = 1'b0;
    ex_br_valid = 1'b1; ex_br_taken = 1'b1;
    tick();
    // Counter is 01; a same-cycle update must not be visible to the read.
    probe(32'h100, 32'hFE000EE3);
    check_eq("bht_sat0_pred", 64'(pred_flag), 64'h0);
    stall_id = 1'b1;
    tick();
    ex_br_valid = 1'b0;
    if_valid = 1'b0;
    check_eq("bht_collide_stored", 64'(id_pred_taken), 64'h0);
    probe(32'h100, 32'hFE000EE3);
    check_eq("bht_after_collide_pred", 64'(pred_flag), 64'h1);
    if_valid = 1'b0;
    stall_id = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
